// File: rtl/instr_executor_if.sv
// Bus bundle between the instruction executor and its environment:
// run control, instruction-register read port and result handshake.
interface instr_executor_if;
  logic               start;
  logic [4:0]         first_addr;
  logic [5:0]         num_instr;
  logic [4:0]         read_pointer;
  logic [67:0]        instruction_word; // {opc[3:0], op_a[31:0], op_b[31:0]}
  logic signed [63:0] result;
  logic [3:0]         result_opc;
  logic               result_valid;
  logic               result_ready;
  logic               div0_err;
  logic               busy;
  logic               done;

  // Environment side: launches runs, serves the register file, consumes results
  modport master (
    output start, first_addr, num_instr, instruction_word, result_ready,
    input  read_pointer, result, result_opc, result_valid, div0_err, busy, done
  );

  // Executor side
  modport slave (
    input  start, first_addr, num_instr, instruction_word, result_ready,
    output read_pointer, result, result_opc, result_valid, div0_err, busy, done
  );
endinterface

// File: rtl/instr_executor.sv
// Sequential instruction executor: walks a run of instruction-register
// entries, evaluates each one at 64-bit signed width and hands results out
// through a valid/ready handshake.
module instr_executor #(
  parameter logic signed [63:0] DIV0_RESULT = 64'sd0
) (
  input logic            clk,
  input logic            reset,
  instr_executor_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  logic [1:0]         state_q,  state_d;
  logic [4:0]         rp_q,     rp_d;
  logic [5:0]         rem_q,    rem_d;
  logic [67:0]        instr_q,  instr_d;
  logic signed [63:0] result_q, result_d;
  logic [3:0]         opc_q,    opc_d;
  logic               div0_q,   div0_d;
  logic               valid_q,  valid_d;
  logic               done_q,   done_d;

  logic [3:0]         opc_w;
  logic signed [63:0] a_w, b_w, b_safe_w, alu_res_w;
  logic               b_nz_w, alu_div0_w;

  assign opc_w    = instr_q[67:64];
  assign a_w      = {{32{instr_q[63]}}, instr_q[63:32]};
  assign b_w      = {{32{instr_q[31]}}, instr_q[31:0]};
  assign b_nz_w   = (b_w != 64'sd0);
  // Divisor forced to 1 when zero so the unused quotient path never goes X
  assign b_safe_w = b_nz_w ? b_w : 64'sd1;

  // Evaluate the latched instruction
  always_comb begin
    alu_res_w  = '0;
    alu_div0_w = 1'b0;
    case (opc_w)
      OPC_ZERO:  alu_res_w = '0;
      OPC_PASSA: alu_res_w = a_w;
      OPC_PASSB: alu_res_w = b_w;
      OPC_ADD:   alu_res_w = a_w + b_w;
      OPC_SUB:   alu_res_w = a_w - b_w;
      OPC_MULT:  alu_res_w = a_w * b_w;
      OPC_DIV: begin
        alu_res_w  = b_nz_w ? (a_w / b_safe_w) : DIV0_RESULT;
        alu_div0_w = !b_nz_w;
      end
      OPC_MOD: begin
        alu_res_w  = b_nz_w ? (a_w % b_safe_w) : DIV0_RESULT;
        alu_div0_w = !b_nz_w;
      end
      default:   alu_res_w = '0;
    endcase
  end

  // Run sequencing: next-state for FSM, pointer, counter and result registers
  always_comb begin
    state_d  = state_q;
    rp_d     = rp_q;
    rem_d    = rem_q;
    instr_d  = instr_q;
    result_d = result_q;
    opc_d    = opc_q;
    div0_d   = div0_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          rp_d    = bus.first_addr;
          rem_d   = (bus.num_instr == 6'd0) ? 6'd32 : bus.num_instr;
        end
      end
      FETCH: begin
        instr_d = bus.instruction_word;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_res_w;
        opc_d    = opc_w;
        div0_d   = alu_div0_w;
        valid_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (valid_q && bus.result_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - 6'd1;
          if (rem_q == 6'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rp_d    = rp_q + 5'd1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rp_q     <= '0;
      rem_q    <= '0;
      instr_q  <= '0;
      result_q <= '0;
      opc_q    <= '0;
      div0_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rp_q     <= rp_d;
      rem_q    <= rem_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      opc_q    <= opc_d;
      div0_q   <= div0_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign bus.read_pointer = rp_q;
  assign bus.result       = result_q;
  assign bus.result_opc   = opc_q;
  assign bus.result_valid = valid_q;
  assign bus.div0_err     = div0_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_instr_executor.sv
// Self-checking bench for instr_executor: directed runs plus randomized
// runs compared against an arithmetic reference model of each instruction.
module tb_instr_executor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_executor_if bus();

  instr_executor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [67:0] regs [32];
  assign bus.instruction_word = regs[bus.read_pointer];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] mk(input int op, input int a, input int b);
    logic [3:0] o;
    o = op[3:0];
    return {o, a, b};
  endfunction

  // Reference: instruction semantics at 64-bit signed width
  function automatic void model(input logic [67:0] w, output longint r, output longint d0);
    int     sa, sb;
    longint a, b;
    int unsigned op;
    sa = w[63:32];
    sb = w[31:0];
    a  = sa;
    b  = sb;
    op = {28'd0, w[67:64]};
    d0 = 0;
    case (op)
      0: r = 0;
      1: r = a;
      2: r = b;
      3: r = a + b;
      4: r = a - b;
      5: r = a * b;
      6: if (b == 0) begin r = 0; d0 = 1; end else r = a / b;
      7: if (b == 0) begin r = 0; d0 = 1; end else r = a % b;
      default: r = 0;
    endcase
  endfunction

  function automatic logic [67:0] rand_word();
    int op, a, b;
    op = $urandom_range(0, 15);
    a  = ($urandom_range(0, 1) == 1) ? int'($urandom) : ($urandom_range(0, 200) - 100);
    case ($urandom_range(0, 3))
      0:       b = 0;
      1:       b = int'($urandom);
      default: b = $urandom_range(0, 40) - 20;
    endcase
    return mk(op, a, b);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rp"},    bus.read_pointer, 0);
    check({tag, "_res"},   bus.result, 0);
    check({tag, "_opc"},   bus.result_opc, 0);
    check({tag, "_valid"}, bus.result_valid, 0);
    check({tag, "_div0"},  bus.div0_err, 0);
    check({tag, "_done"},  bus.done, 0);
    check({tag, "_busy"},  bus.busy, 0);
  endtask

  // One complete run; bp enables random backpressure, poke pulses start while busy
  task automatic run(input int first, input int n, input bit bp, input bit poke);
    int     cnt, addr, waitc, h;
    longint er, ed;
    cnt = (n == 0) ? 32 : n;
    bus.first_addr   = first[4:0];
    bus.num_instr    = n[5:0];
    bus.result_ready = !bp;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("rp_after_start", bus.read_pointer, first % 32);
    for (int k = 0; k < cnt; k++) begin
      addr = (first + k) % 32;
      model(regs[addr], er, ed);
      waitc = 0;
      while (!bus.result_valid && waitc < 10) begin
        tick();
        waitc++;
      end
      check("latency", waitc, 2);
      check("rp", bus.read_pointer, addr);
      check("result", bus.result, er);
      check("opc", bus.result_opc, longint'(regs[addr][67:64]));
      check("div0", bus.div0_err, ed);
      check("done_low", bus.done, 0);
      if (bp) begin
        h = (k == 0) ? 5 : $urandom_range(0, 3);
        for (int j = 0; j < h; j++) begin
          if (poke && k == 0 && j == 0) begin
            bus.start      = 1'b1;
            bus.first_addr = bus.first_addr + 5'd7;
            bus.num_instr  = 6'd1;
          end
          tick();
          bus.start = 1'b0;
          check("hold_valid", bus.result_valid, 1);
          check("hold_result", bus.result, er);
          check("hold_opc", bus.result_opc, longint'(regs[addr][67:64]));
          check("hold_div0", bus.div0_err, ed);
          check("hold_rp", bus.read_pointer, addr);
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
      end else begin
        tick();
      end
      check("valid_drop", bus.result_valid, 0);
      if (k == cnt - 1) begin
        check("done_pulse", bus.done, 1);
        check("busy_end", bus.busy, 0);
        tick();
        check("done_single", bus.done, 0);
      end else begin
        check("done_mid", bus.done, 0);
        check("rp_advance", bus.read_pointer, (addr + 1) % 32);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.first_addr   = '0;
    bus.num_instr    = '0;
    bus.result_ready = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Basic run with ready tied high
    regs[0] = mk(3, 5, 7);
    regs[1] = mk(4, 3, 10);
    regs[2] = mk(5, -4, 6);
    run(0, 3, 1'b0, 1'b0);

    // Divide by zero then signed modulo
    regs[10] = mk(6, 9, 0);
    regs[11] = mk(7, -7, 2);
    run(10, 2, 1'b0, 1'b0);

    // Backpressure with a start pulse while busy
    for (int i = 0; i < 32; i++) regs[i] = rand_word();
    run(5, 3, 1'b1, 1'b1);

    // Full-length run wrapping past address 31
    run(30, 0, 1'b0, 1'b0);

    // Reset during HOLD of the second instruction
    bus.first_addr   = 5'd4;
    bus.num_instr    = 6'd3;
    bus.result_ready = 1'b0;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("rst_first_valid", bus.result_valid, 1);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    tick();
    tick();
    check("rst_second_valid", bus.result_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midrun_reset");
    for (int j = 0; j < 4; j++) begin
      tick();
      check("post_reset_done", bus.done, 0);
      check("post_reset_busy", bus.busy, 0);
      check("post_reset_valid", bus.result_valid, 0);
    end

    // Randomized runs
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = rand_word();
      run($urandom_range(0, 31), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
